// File: rtl/awg_sweep_ctrl_if.sv
`default_nettype none
// ==========================================================================
// awg_sweep_ctrl_if : control/status bundle between host regs and sweeper.
// Rev 1.0
// ==========================================================================
interface awg_sweep_ctrl_if #(
   parameter int PHASE_WIDTH = 32,
   parameter int DWELL_WIDTH = 16
);
   logic                   start;
   logic                   abort;
   logic                   continuous;
   logic [PHASE_WIDTH-1:0] Fre_start;
   logic [PHASE_WIDTH-1:0] Fre_stop;
   logic [PHASE_WIDTH-1:0] Fre_step;
   logic [DWELL_WIDTH-1:0] dwell;
   logic [PHASE_WIDTH-1:0] Fre_word;
   logic                   busy;
   logic                   done;
   logic                   sweep_sync;

   modport master (
      output start, abort, continuous, Fre_start, Fre_stop, Fre_step, dwell,
      input  Fre_word, busy, done, sweep_sync
   );

   modport slave (
      input  start, abort, continuous, Fre_start, Fre_stop, Fre_step, dwell,
      output Fre_word, busy, done, sweep_sync
   );
endinterface
`default_nettype wire

// File: rtl/awg_sweep_ctrl.sv
`default_nettype none
// ==========================================================================
// awg_sweep_ctrl : linear frequency-sweep sequencer for one AWG channel.
// Define SWEEP_BIDIR_EN for up/down passes.               Rev 1.0
// ==========================================================================
module awg_sweep_ctrl #(
   parameter int PHASE_WIDTH = 32,
   parameter int DWELL_WIDTH = 16
) (
   input  logic            clk_in,
   input  logic            RST,
   awg_sweep_ctrl_if.slave bus
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
`ifdef SWEEP_BIDIR_EN
   localparam logic [1:0] S_DOWN = 2'd2;
`endif

   logic [1:0]             state, state_nxt;
   logic [PHASE_WIDTH-1:0] start_q, stop_q, step_q;
   logic [PHASE_WIDTH-1:0] word, word_nxt, up_next;
   logic [PHASE_WIDTH:0]   up_sum;
   logic [DWELL_WIDTH-1:0] hold_q, cnt, cnt_nxt, dwell_m1;
   logic                   cont_q, degen_q;
   logic                   done_r, done_nxt, sync_r, sync_nxt;
   logic                   launch, expire, up_more, pass_end;

   assign launch   = (state == S_IDLE) && bus.start && !bus.abort;
   assign dwell_m1 = (bus.dwell == '0) ? '0 : bus.dwell - DWELL_WIDTH'(1);
   assign expire   = (cnt == '0);
   // Sum carries into bit PHASE_WIDTH so an overflowing step clamps to stop.
   assign up_sum   = {1'b0, word} + {1'b0, step_q};
   assign up_next  = (up_sum > {1'b0, stop_q}) ? stop_q : up_sum[PHASE_WIDTH-1:0];
   assign up_more  = !degen_q && (word < stop_q);

`ifdef SWEEP_BIDIR_EN
   logic [PHASE_WIDTH:0]   dn_diff;
   logic [PHASE_WIDTH-1:0] dn_next;
   logic                   dn_more;
   assign dn_diff  = {1'b0, word} - {1'b0, step_q};
   assign dn_next  = (dn_diff[PHASE_WIDTH] || (dn_diff[PHASE_WIDTH-1:0] < start_q))
                     ? start_q : dn_diff[PHASE_WIDTH-1:0];
   assign dn_more  = (word > start_q);
   // A non-degenerate up leg turns around rather than ending the pass.
   assign pass_end = (state == S_RUN) ? (!up_more && degen_q) : !dn_more;
`else
   assign pass_end = !up_more;
`endif

   always_ff @(posedge clk_in) begin
      if (RST) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (launch) state_nxt = S_RUN;
         default: begin
            if (bus.abort) begin
               state_nxt = S_IDLE;
            end else if (expire) begin
               if (pass_end)
                  state_nxt = cont_q ? S_RUN : S_IDLE;
`ifdef SWEEP_BIDIR_EN
               else
                  state_nxt = (state == S_RUN && up_more) ? S_RUN : S_DOWN;
`endif
            end
         end
      endcase
   end

   always_comb begin
      word_nxt = word;
      cnt_nxt  = cnt;
      done_nxt = 1'b0;
      sync_nxt = 1'b0;
      if (launch) begin
         word_nxt = bus.Fre_start;
         cnt_nxt  = dwell_m1;
         sync_nxt = 1'b1;
      end else if (state != S_IDLE && !bus.abort) begin
         if (!expire) begin
            cnt_nxt = cnt - DWELL_WIDTH'(1);
         end else if (pass_end) begin
            if (cont_q) begin
               word_nxt = start_q;
               cnt_nxt  = hold_q;
               sync_nxt = 1'b1;
            end else begin
               done_nxt = 1'b1;
            end
         end else begin
            cnt_nxt = hold_q;
`ifdef SWEEP_BIDIR_EN
            word_nxt = (state == S_RUN && up_more) ? up_next : dn_next;
`else
            word_nxt = up_next;
`endif
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (RST) begin
         word    <= '0;
         cnt     <= '0;
         done_r  <= 1'b0;
         sync_r  <= 1'b0;
         start_q <= '0;
         stop_q  <= '0;
         step_q  <= '0;
         hold_q  <= '0;
         cont_q  <= 1'b0;
         degen_q <= 1'b0;
      end else begin
         word   <= word_nxt;
         cnt    <= cnt_nxt;
         done_r <= done_nxt;
         sync_r <= sync_nxt;
         if (launch) begin
            start_q <= bus.Fre_start;
            stop_q  <= bus.Fre_stop;
            step_q  <= bus.Fre_step;
            hold_q  <= dwell_m1;
            cont_q  <= bus.continuous;
            degen_q <= (bus.Fre_step == '0) || (bus.Fre_start >= bus.Fre_stop);
         end
      end
   end

   assign bus.Fre_word   = word;
   assign bus.busy       = (state != S_IDLE);
   assign bus.done       = done_r;
   assign bus.sweep_sync = sync_r;
endmodule
`default_nettype wire
